// File: rtl/serial_add_ctrl.sv
//------------------------------------------------------------------------------
// serial_add_ctrl : bit-serial adder, one full-adder cell reused over WIDTH edges
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module serial_add_half_adder (
   input  logic a,
   input  logic b,
   output logic s,
   output logic c
);
   assign s = a ^ b;
   assign c = a & b;
endmodule

module serial_add_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic             Clk,
   input  logic             Rst_n,
   input  logic             Start,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic             Busy,
   output logic             Done,
   output logic [WIDTH-1:0] Sum,
   output logic             CarryOut
);

   localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   a_sr_q, a_sr_d;
   logic [WIDTH-1:0]   b_sr_q, b_sr_d;
   logic [WIDTH-1:0]   sum_sr_q, sum_sr_d;
   logic [WIDTH-1:0]   sum_q, sum_d;
   logic               carry_q, carry_d;
   logic               cout_q, cout_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;

   logic               ha0_s, ha0_c, ha1_s, ha1_c;
   logic               bit_sum, carry_next;
   logic [WIDTH-1:0]   sum_shift;

   // Full adder = two half adders; carry is the OR of their carries.
   serial_add_half_adder u_ha0 (
      .a (a_sr_q[0]),
      .b (b_sr_q[0]),
      .s (ha0_s),
      .c (ha0_c)
   );

   serial_add_half_adder u_ha1 (
      .a (ha0_s),
      .b (carry_q),
      .s (ha1_s),
      .c (ha1_c)
   );

   assign bit_sum    = ha1_s;
   assign carry_next = ha0_c | ha1_c;

   always_comb begin
      sum_shift            = sum_sr_q >> 1;
      sum_shift[WIDTH-1]   = bit_sum;
   end

   always_comb begin
      state_d  = state_q;
      a_sr_d   = a_sr_q;
      b_sr_d   = b_sr_q;
      sum_sr_d = sum_sr_q;
      sum_d    = sum_q;
      carry_d  = carry_q;
      cout_d   = cout_q;
      cnt_d    = cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (Start) begin
               a_sr_d  = A;
               b_sr_d  = B;
               carry_d = 1'b0;
               cnt_d   = '0;
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            a_sr_d   = a_sr_q >> 1;
            b_sr_d   = b_sr_q >> 1;
            sum_sr_d = sum_shift;
            carry_d  = carry_next;
            cnt_d    = cnt_q + CNT_W'(1);
            // Final bit: publish result including this edge's sum bit and carry.
            if (cnt_q == LAST_CNT) begin
               sum_d   = sum_shift;
               cout_d  = carry_next;
               state_d = ST_DONE;
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         state_q  <= ST_IDLE;
         a_sr_q   <= '0;
         b_sr_q   <= '0;
         sum_sr_q <= '0;
         sum_q    <= '0;
         carry_q  <= 1'b0;
         cout_q   <= 1'b0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         a_sr_q   <= a_sr_d;
         b_sr_q   <= b_sr_d;
         sum_sr_q <= sum_sr_d;
         sum_q    <= sum_d;
         carry_q  <= carry_d;
         cout_q   <= cout_d;
         cnt_q    <= cnt_d;
      end
   end

   assign Busy     = (state_q != ST_IDLE);
   assign Done     = (state_q == ST_DONE);
   assign Sum      = sum_q;
   assign CarryOut = cout_q;

endmodule

`default_nettype wire

// File: tb/tb_serial_add_ctrl.sv
//------------------------------------------------------------------------------
// tb_serial_add_ctrl : self-checking bench for serial_add_ctrl (WIDTH=8 and WIDTH=1)
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_serial_add_ctrl;

   logic       Clk;
   logic       Rst_n;
   logic       Start;
   logic [7:0] A, B;
   logic       Busy, Done, CarryOut;
   logic [7:0] Sum;

   logic       Start1;
   logic [0:0] A1, B1, Sum1;
   logic       Busy1, Done1, CarryOut1;

   int tests_run    = 0;
   int tests_failed = 0;

   logic [8:0] sb[$];

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic [7:0] sum;
      logic       co;
   } vec_t;

   vec_t vecs[7];

   serial_add_ctrl #(.WIDTH(8)) dut (
      .Clk      (Clk),
      .Rst_n    (Rst_n),
      .Start    (Start),
      .A        (A),
      .B        (B),
      .Busy     (Busy),
      .Done     (Done),
      .Sum      (Sum),
      .CarryOut (CarryOut)
   );

   serial_add_ctrl #(.WIDTH(1)) dut1 (
      .Clk      (Clk),
      .Rst_n    (Rst_n),
      .Start    (Start1),
      .A        (A1),
      .B        (B1),
      .Busy     (Busy1),
      .Done     (Done1),
      .Sum      (Sum1),
      .CarryOut (CarryOut1)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Result stability between Done pulses and single-cycle Done width.
   logic       mon_en = 1'b0;
   logic       mon_primed = 1'b0;
   logic       prev_done;
   logic [8:0] prev_res;

   always @(negedge Clk) begin
      if (mon_en) begin
         if (mon_primed) begin
            if (prev_done)
               chk("done_width_mon", {31'd0, Done}, 32'd0);
            if (!Done)
               chk("result_stable", {23'd0, CarryOut, Sum}, {23'd0, prev_res});
         end
         mon_primed = 1'b1;
         prev_done  = Done;
         prev_res   = {CarryOut, Sum};
      end else begin
         mon_primed = 1'b0;
      end
   end

   task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic [8:0] exp_in);
      int         lat;
      bit         seen;
      logic [8:0] exp;
      @(negedge Clk);
      A     = a;
      B     = b;
      Start = 1'b1;
      sb.push_back(exp_in);
      @(negedge Clk);
      Start = 1'b0;
      A     = 8'($urandom);
      B     = 8'($urandom);
      chk("busy_after_accept", {31'd0, Busy}, 32'd1);
      seen = 1'b0;
      lat  = 0;
      for (int i = 1; i <= 20 && !seen; i++) begin
         @(negedge Clk);
         if (i == 3) Start = 1'b1;
         if (i == 5) Start = 1'b0;
         if (Done) begin
            seen = 1'b1;
            lat  = i;
         end
      end
      Start = 1'b0;
      chk("done_seen", {31'd0, seen}, 32'd1);
      exp = sb.pop_front();
      if (seen) begin
         chk("latency", lat, 32'd8);
         chk("sum", {24'd0, Sum}, {24'd0, exp[7:0]});
         chk("carry", {31'd0, CarryOut}, {31'd0, exp[8]});
         @(negedge Clk);
         chk("done_one_cycle", {31'd0, Done}, 32'd0);
         chk("busy_cleared", {31'd0, Busy}, 32'd0);
      end
   endtask

   task automatic w1_op(input logic a, input logic b);
      logic [1:0] exp;
      exp = {1'b0, a} + {1'b0, b};
      @(negedge Clk);
      A1     = a;
      B1     = b;
      Start1 = 1'b1;
      @(negedge Clk);
      Start1 = 1'b0;
      chk("w1_busy", {31'd0, Busy1}, 32'd1);
      chk("w1_done_not_yet", {31'd0, Done1}, 32'd0);
      @(negedge Clk);
      chk("w1_done", {31'd0, Done1}, 32'd1);
      chk("w1_sum", {31'd0, Sum1}, {31'd0, exp[0]});
      chk("w1_carry", {31'd0, CarryOut1}, {31'd0, exp[1]});
      @(negedge Clk);
      chk("w1_idle", {31'd0, Busy1}, 32'd0);
   endtask

   initial begin
      #1000000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      int         lat;
      int         prev_t;
      int         done_cnt;
      bit         seen;
      logic [7:0] ra, rb;

      vecs[0] = '{a: 8'h0F, b: 8'h01, sum: 8'h10, co: 1'b0};
      vecs[1] = '{a: 8'hFF, b: 8'h01, sum: 8'h00, co: 1'b1};
      vecs[2] = '{a: 8'hFF, b: 8'hFF, sum: 8'hFE, co: 1'b1};
      vecs[3] = '{a: 8'h00, b: 8'h00, sum: 8'h00, co: 1'b0};
      vecs[4] = '{a: 8'h80, b: 8'h80, sum: 8'h00, co: 1'b1};
      vecs[5] = '{a: 8'hAA, b: 8'h55, sum: 8'hFF, co: 1'b0};
      vecs[6] = '{a: 8'h3C, b: 8'h4B, sum: 8'h87, co: 1'b0};

      Rst_n  = 1'b0;
      Start  = 1'b0;
      A      = 8'h5A;
      B      = 8'hA5;
      Start1 = 1'b0;
      A1     = 1'b0;
      B1     = 1'b0;
      repeat (3) @(negedge Clk);
      chk("reset_busy", {31'd0, Busy}, 32'd0);
      chk("reset_done", {31'd0, Done}, 32'd0);
      chk("reset_sum", {24'd0, Sum}, 32'd0);
      chk("reset_carry", {31'd0, CarryOut}, 32'd0);
      chk("reset_w1", {28'd0, Busy1, Done1, Sum1, CarryOut1}, 32'd0);
      Rst_n = 1'b1;
      @(negedge Clk);
      chk("idle_no_start", {31'd0, Busy}, 32'd0);
      mon_en = 1'b1;

      // Table-driven directed vectors
      for (int i = 0; i < 7; i++)
         run_op(vecs[i].a, vecs[i].b, {vecs[i].co, vecs[i].sum});

      // Start held high: back-to-back ops every 10 cycles, mid-run operand change ignored
      @(negedge Clk);
      A      = 8'h12;
      B      = 8'h34;
      Start  = 1'b1;
      prev_t = 0;
      for (int op = 0; op < 3; op++) begin
         sb.push_back(9'h046);
         seen = 1'b0;
         lat  = 0;
         for (int i = 1; i <= 25 && !seen; i++) begin
            @(negedge Clk);
            if (i == 4) A = 8'hAA;
            if (i == 7) A = 8'h12;
            if (Done) begin
               seen = 1'b1;
               lat  = i;
            end
         end
         if (op == 2) Start = 1'b0;
         chk("held_done_seen", {31'd0, seen}, 32'd1);
         chk("held_interval", lat, (op == 0) ? 32'd9 : 32'd10);
         prev_t = sb.pop_front();
         chk("held_sum", {23'd0, CarryOut, Sum}, prev_t);
      end
      @(negedge Clk);
      chk("held_idle", {31'd0, Busy}, 32'd0);

      // Asynchronous reset in RUN cycle 4
      @(negedge Clk);
      A     = 8'h55;
      B     = 8'h11;
      Start = 1'b1;
      @(negedge Clk);
      Start = 1'b0;
      repeat (3) @(negedge Clk);
      mon_en = 1'b0;
      #2;
      Rst_n = 1'b0;
      #1;
      chk("arst_busy", {31'd0, Busy}, 32'd0);
      chk("arst_done", {31'd0, Done}, 32'd0);
      chk("arst_sum", {24'd0, Sum}, 32'd0);
      chk("arst_carry", {31'd0, CarryOut}, 32'd0);
      @(negedge Clk);
      Rst_n = 1'b1;
      done_cnt = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge Clk);
         if (Done) done_cnt++;
      end
      chk("arst_no_done", done_cnt, 32'd0);
      chk("arst_sum_held", {23'd0, CarryOut, Sum}, 32'd0);
      mon_en = 1'b1;
      run_op(8'h01, 8'h02, 9'h003);

      // WIDTH=1 instance, all operand combinations
      for (int i = 0; i < 4; i++) begin
         logic [1:0] ab;
         ab = 2'(i);
         w1_op(ab[1], ab[0]);
      end

      // Randomized operands against golden A+B
      for (int n = 0; n < 200; n++) begin
         ra = 8'($urandom);
         rb = 8'($urandom);
         run_op(ra, rb, {1'b0, ra} + {1'b0, rb});
      end

      mon_en = 1'b0;
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/serial_add_ctrl.md
Name: serial_add_ctrl

Overview:
Bit-serial adder sequencer. It reuses a single full-adder cell, built from two half-adder cells plus an OR for the carry, over WIDTH clock cycles to add two WIDTH-bit operands. A single-pulse Start / Busy / Done handshake frames each operation. It is the team's area-minimal add engine for wide operands, where a parallel ripple adder is too costly.

Parameters:
WIDTH, 8, operand and sum width in bits; legal range 1..32.

Ports:
Clk  input  1  rising-edge clock.
Rst_n  input  1  asynchronous active-low reset.
Start  input  1  request an add; sampled only in IDLE.
A  input  WIDTH  operand A; captured on the edge that accepts Start.
B  input  WIDTH  operand B; captured on the edge that accepts Start.
Busy  output  1  high while in RUN or DONE.
Done  output  1  one-cycle pulse: result valid.
Sum  output  WIDTH  registered sum, held until the next completion.
CarryOut  output  1  registered carry out of the MSB, held like Sum.

Behaviour:
- Reset: clock is a single domain; reset is asynchronous and active-low, asserted immediately and released synchronously to Clk.
  - While Rst_n=0: state IDLE; Busy=0, Done=0, Sum=0, CarryOut=0; shift registers, carry flop and bit counter cleared.
  - Reset mid-RUN or mid-DONE aborts the operation; no Done pulse; outputs go to 0.
- States: IDLE, RUN, DONE. Busy=(state!=IDLE); Done=(state==DONE). All outputs are registered, with no combinational path from inputs.
- IDLE:
  - Start=1 at edge k: load A and B into shift regs, clear carry flop, clear counter, go to RUN.
  - Start=0: stay in IDLE.
- RUN, per edge:
  - s = a_lsb ^ b_lsb ^ c; c_next = majority(a_lsb, b_lsb, c), computed through the two half-adder cells.
  - Shift the A and B regs right by 1.
  - Shift the sum reg right by 1, inserting s at the MSB.
  - Counter increments.
  - On the edge where counter==WIDTH-1: load Sum from the final sum-reg value (including the current s), load CarryOut from c_next, go to DONE.
- Latency: RUN occupies edges k+1..k+WIDTH. Done and the new Sum/CarryOut are visible after edge k+WIDTH. The next Start can be accepted at edge k+WIDTH+2 at the earliest.
- DONE: lasts exactly one cycle, then returns to IDLE unconditionally.
- Start while Busy=1 (RUN or DONE) is ignored and not queued. A, B and Start are don't-care outside the accepting edge.
- Operand changes during RUN have no effect; operands are captured at acceptance only.
- Arithmetic: result is {CarryOut,Sum} = A+B, unsigned, modulo 2^(WIDTH+1), with no overflow loss.
- Counter width: clog2(WIDTH), minimum 1 bit.
- WIDTH=1: RUN lasts one edge; Done is visible after edge k+1.
- Sum and CarryOut change only on the DONE-entry edge or on reset.

Test Plan:
1. WIDTH=8, A=8'h0F, B=8'h01, Start pulsed at edge k.
   -> Busy=1 after edge k.
   -> Done=1 for exactly one cycle after edge k+8.
   -> Sum=8'h10, CarryOut=0.
   -> Busy=0 after edge k+9.
2. A=8'hFF, B=8'h01 -> Sum=8'h00, CarryOut=1. Then A=8'hFF, B=8'hFF -> Sum=8'hFE, CarryOut=1. Then A=0, B=0 -> Sum=0, CarryOut=0, with Done still pulsing.
3. Start held high continuously with A=8'h12, B=8'h34.
   -> Done every 10 cycles, Sum=8'h46 each time.
   -> Start during RUN/DONE is ignored; the operand change to A=8'hAA mid-RUN does not alter the in-flight result.
4. Rst_n driven low asynchronously (between edges) at cycle 4 of RUN.
   -> Busy, Done, Sum, CarryOut = 0 immediately; no Done pulse.
   -> After release, a new add of A=8'h01, B=8'h02 yields Sum=8'h03 with normal latency.
5. WIDTH=1 build: A=1, B=1 -> Done after edge k+1, Sum=0, CarryOut=1. A=1, B=0 -> Sum=1, CarryOut=0.
6. Randomized WIDTH=8 operands, 200 operations, compared against a golden A+B model. Check Sum/CarryOut stability between Done pulses and Done width = 1 cycle.
